wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order writeback stage (output of the W pipeline register) and a long-latency execution unit (LLU: multiplier/divider) that returns results out of band. W-stage writes have priority. A blocked LLU result is parked in a one-entry buffer. If the buffer starves for too long, the arbiter freezes the pipeline for one cycle to drain it. The block sits between the W pipeline register, the LLU result interface and the register file, and feeds the hazard unit with the pending destination.

## Interface
- DATA_WIDTH, 32, register data width
- REGISTER_ADDRESS_WIDTH, 5, register index width
- STARVE_LIMIT, 4, maximum number of blocked HELD cycles before a forced drain; legal range 1..15

- clk_i  input  1  clock; all state updates on its rising edge
- rst_ni  input  1  reset; asynchronous, active-low
- RegWriteW_i  input  1  W-stage write request
- RdW_i  input  REGISTER_ADDRESS_WIDTH  W-stage destination register
- ResultW_i  input  DATA_WIDTH  W-stage write data (already muxed by ResultSrcW)
- LluValid_i  input  1  LLU result valid
- LluRd_i  input  REGISTER_ADDRESS_WIDTH  LLU destination register
- LluResult_i  input  DATA_WIDTH  LLU result
- LluReady_o  output  1  arbiter accepts an LLU result this cycle
- RfWe_o  output  1  register-file write enable
- RfRd_o  output  REGISTER_ADDRESS_WIDTH  register-file write address
- RfWd_o  output  DATA_WIDTH  register-file write data
- StallPipe_o  output  1  freeze all pipeline registers, including W, for this cycle
- PendingValid_o  output  1  buffer holds an unwritten LLU result
- PendingRd_o  output  REGISTER_ADDRESS_WIDTH  destination of the buffered result; 0 when empty

## Operation
- wW = RegWriteW_i & (RdW_i != 0). A W write to x0 counts as no write and leaves the port free.
- LLU transfer = LluValid_i & LluReady_o. A transfer with LluRd_i == 0 is accepted and discarded: no write, no buffering.
- FSM states: IDLE (buffer empty), HELD (buffer full), STARVED (buffer full, forced drain). There is a saturating blocked-cycle counter cnt, sized for 0..15.
- IDLE:
  - LluReady_o = 1.
  - Transfer and !wW: the LLU result is written straight through to the port. Stay IDLE.
  - Transfer and wW: the W write goes to the port, the LLU result is captured into the buffer, cnt <= 0, next state HELD.
  - No transfer: the port follows W.
- HELD:
  - LluReady_o = 0. PendingValid_o = 1.
  - !wW: the port writes the buffer, the buffer is cleared, next state IDLE.
  - wW: the W write goes to the port and cnt <= cnt + 1. When cnt + 1 == STARVE_LIMIT, next state STARVED; otherwise stay HELD.
- STARVED:
  - StallPipe_o = 1, LluReady_o = 0.
  - The port writes the buffer regardless of wW. The W instruction is held by the stall and is not written this cycle.
  - Buffer cleared, next state IDLE.
- Port mux: RfWe_o / RfRd_o / RfWd_o select the buffer in STARVED and in HELD with !wW. They select the LLU inputs for an IDLE pass-through. Otherwise they select the W inputs. RfWe_o = 0 whenever no source writes; RfRd_o and RfWd_o are then don't-care.
- WAW ordering is not resolved here. The hazard unit must stall issue of any instruction whose rd equals PendingRd_o while PendingValid_o = 1, or equals an in-flight LLU rd.
- Outputs are combinational from state and inputs. StallPipe_o, PendingValid_o and PendingRd_o depend on state only (Moore).

## Timing
- Reset (rst_ni low, asynchronous): state IDLE, cnt 0, buffer cleared (rd 0, data 0). While reset is asserted: RfWe_o = 0, LluReady_o = 0, StallPipe_o = 0, PendingValid_o = 0, PendingRd_o = 0.
- First cycle after reset release: LluReady_o = 1.
- Reset mid-operation discards any buffered result. The LLU shares rst_ni and therefore loses in-flight operations as well.
- Pass-through latency is 0 cycles: the write happens in the transfer cycle.
- Buffered write:
  - Captured at edge t. The earliest write is the cycle after t.
  - The latest write is STARVE_LIMIT + 1 cycles after capture: STARVE_LIMIT blocked HELD cycles, then one STARVED cycle.
- StallPipe_o is high for exactly one cycle per starvation event and is never high in consecutive cycles.
- After a drain, LluReady_o returns high in the following cycle (IDLE). No transfer is accepted in the drain cycle itself.

## Test plan
- IDLE, RegWriteW_i=0, LluValid_i=1, LluRd_i=5, LluResult_i=0xDEADBEEF -> same cycle RfWe_o=1, RfRd_o=5, RfWd_o=0xDEADBEEF; state stays IDLE.
- IDLE, W writes x3=0x11 while LLU presents x7=0x22 -> x3 written; next cycle PendingValid_o=1, PendingRd_o=7, LluReady_o=0. Drop RegWriteW_i -> x7=0x22 written, IDLE the cycle after.
- STARVE_LIMIT=4, buffer holds x9, W writes every cycle -> 4 W writes in HELD, then StallPipe_o=1 for one cycle with RfRd_o=9. The held W instruction is written in the next cycle.
- LLU result with LluRd_i=0 while W writes x4 -> only x4 written, PendingValid_o stays 0. W write to x0 alongside LLU x6 -> x6 passes through directly.
- rst_ni pulled low asynchronously while in HELD with buffer x12 -> RfWe_o, PendingValid_o and LluReady_o drop immediately. After release: IDLE, PendingRd_o=0, x12 never written.
- Random W/LLU traffic for 10k cycles against a reference model -> every accepted LLU result with nonzero rd is written exactly once, every W write is written exactly once and in order, and StallPipe_o is never high in two consecutive cycles.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order writeback
// stage (W pipeline register) and a long-latency unit (multiplier/divider)
// whose results arrive out of band. W-stage writes win. An LLU result that
// loses arbitration is parked in a one-entry buffer and drained on the next
// cycle the W stage leaves the port free. If W keeps the port busy for
// STARVE_LIMIT consecutive cycles, the pipeline is frozen for one cycle so
// the buffer can drain.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   RegWriteW_i     W-stage write request
//   RdW_i           W-stage destination register
//   ResultW_i       W-stage write data
//   LluValid_i      LLU result valid
//   LluRd_i         LLU destination register
//   LluResult_i     LLU result data
//   LluReady_o      an LLU result is accepted this cycle
//   RfWe_o          register-file write enable
//   RfRd_o          register-file write address
//   RfWd_o          register-file write data
//   StallPipe_o     freeze every pipeline register (W included) this cycle
//   PendingValid_o  buffer holds an unwritten LLU result
//   PendingRd_o     destination of the buffered result, 0 when empty
//
// WAW ordering between the buffered result and younger instructions is the
// hazard unit's job; it watches PendingValid_o / PendingRd_o.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  // Blocked HELD cycles tolerated before a forced drain; legal range 1..15.
  parameter int STARVE_LIMIT           = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              RegWriteW_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic [DATA_WIDTH-1:0]             ResultW_i,
  input  logic                              LluValid_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] LluRd_i,
  input  logic [DATA_WIDTH-1:0]             LluResult_i,
  output logic                              LluReady_o,
  output logic                              RfWe_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] RfRd_o,
  output logic [DATA_WIDTH-1:0]             RfWd_o,
  output logic                              StallPipe_o,
  output logic                              PendingValid_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] PendingRd_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // buffer empty
    ST_HELD    = 2'd1,  // buffer full, waiting for a free port cycle
    ST_STARVED = 2'd2   // buffer full, pipeline frozen to force the drain
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                              state_q;
  logic [3:0]                          cnt_q;
  logic [REGISTER_ADDRESS_WIDTH-1:0]   buf_rd_q;
  logic [DATA_WIDTH-1:0]               buf_data_q;

  logic                                w_wr;
  logic                                llu_xfer;
  logic                                llu_keep;
  logic                                drain;
  logic                                pass;
  logic                                capture;
  logic [3:0]                          cnt_inc;
  logic                                port_we;

  // Request decode. A W write to x0 is not a write, and an accepted LLU
  // result aimed at x0 is simply dropped.
  always_comb begin
    w_wr       = RegWriteW_i & (RdW_i != '0);
    // Gated by rst_ni so the LLU sees "not ready" throughout reset even
    // though the state register already reads IDLE.
    LluReady_o = rst_ni & (state_q == ST_IDLE);
    llu_xfer   = LluValid_i & LluReady_o;
    llu_keep   = llu_xfer & (LluRd_i != '0);
    drain      = (state_q == ST_STARVED) | ((state_q == ST_HELD) & ~w_wr);
    pass       = (state_q == ST_IDLE) & llu_keep & ~w_wr;
    capture    = (state_q == ST_IDLE) & llu_keep & w_wr;
    cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  // Write-port mux: buffer drain beats LLU pass-through beats W.
  always_comb begin
    port_we = w_wr;
    RfRd_o  = RdW_i;
    RfWd_o  = ResultW_i;
    if (drain) begin
      port_we = 1'b1;
      RfRd_o  = buf_rd_q;
      RfWd_o  = buf_data_q;
    end else if (pass) begin
      port_we = 1'b1;
      RfRd_o  = LluRd_i;
      RfWd_o  = LluResult_i;
    end
    RfWe_o = rst_ni & port_we;
  end

  // Moore outputs. buf_rd_q is cleared on every drain, so it already reads
  // 0 whenever the buffer is empty.
  always_comb begin
    StallPipe_o    = (state_q == ST_STARVED);
    PendingValid_o = (state_q != ST_IDLE);
    PendingRd_o    = buf_rd_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q    <= ST_HELD;
            cnt_q      <= 4'd0;
            buf_rd_q   <= LluRd_i;
            buf_data_q <= LluResult_i;
          end
        end
        ST_HELD: begin
          if (!w_wr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
          end else begin
            // cnt counts W writes that blocked the buffer since capture.
            cnt_q <= cnt_inc;
            if (cnt_inc == LIMIT) begin
              state_q <= ST_STARVED;
            end
          end
        end
        ST_STARVED: begin
          // Port drained the buffer this cycle; W was frozen by the stall.
          state_q    <= ST_IDLE;
          cnt_q      <= 4'd0;
          buf_rd_q   <= '0;
          buf_data_q <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= 4'd0;
          buf_rd_q   <= '0;
          buf_data_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
  localparam int NCYC  = 10000;

  logic          clk_i;
  logic          rst_ni;
  logic          RegWriteW_i;
  logic [AW-1:0] RdW_i;
  logic [DW-1:0] ResultW_i;
  logic          LluValid_i;
  logic [AW-1:0] LluRd_i;
  logic [DW-1:0] LluResult_i;
  logic          LluReady_o;
  logic          RfWe_o;
  logic [AW-1:0] RfRd_o;
  logic [DW-1:0] RfWd_o;
  logic          StallPipe_o;
  logic          PendingValid_o;
  logic [AW-1:0] PendingRd_o;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } wr_t;

  wr_t w_q[$];
  wr_t l_q[$];

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(
    .DATA_WIDTH(DW),
    .REGISTER_ADDRESS_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .RegWriteW_i(RegWriteW_i),
    .RdW_i(RdW_i),
    .ResultW_i(ResultW_i),
    .LluValid_i(LluValid_i),
    .LluRd_i(LluRd_i),
    .LluResult_i(LluResult_i),
    .LluReady_o(LluReady_o),
    .RfWe_o(RfWe_o),
    .RfRd_o(RfRd_o),
    .RfWd_o(RfWd_o),
    .StallPipe_o(StallPipe_o),
    .PendingValid_o(PendingValid_o),
    .PendingRd_o(PendingRd_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    RegWriteW_i = wv;
    RdW_i       = wrd;
    ResultW_i   = wd;
    LluValid_i  = lv;
    LluRd_i     = lrd;
    LluResult_i = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd5, 32'h5678);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (RfWe_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b required 0", RfWe_o); end
    checks++;
    if (LluReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b required 0", LluReady_o); end
    checks++;
    if (StallPipe_o !== 1'b0 || PendingValid_o !== 1'b0 || PendingRd_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got stall=%b pv=%b prd=%0d required 0/0/0", StallPipe_o, PendingValid_o, PendingRd_o);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_ni = 1'b1;
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (LluReady_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b required 1", LluReady_o); end
  endtask

  task automatic test_passthrough();
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk_i);
    checks++;
    if (RfWe_o !== 1'b1 || RfRd_o !== 5'd5 || RfWd_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pass_write got we=%b x%0d=%h required we=1 x5=deadbeef", RfWe_o, RfRd_o, RfWd_o);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b0 || LluReady_o !== 1'b1 || RfWe_o !== 1'b0) begin
      errors++;
      $display("FAIL pass_idle got pv=%b rdy=%b we=%b required 0/1/0", PendingValid_o, LluReady_o, RfWe_o);
    end
  endtask

  task automatic test_buffer();
    next_cycle();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    @(negedge clk_i);
    checks++;
    if (RfWe_o !== 1'b1 || RfRd_o !== 5'd3 || RfWd_o !== 32'h11 || LluReady_o !== 1'b1) begin
      errors++;
      $display("FAIL buf_wfirst got we=%b x%0d=%h rdy=%b required x3=11 rdy=1", RfWe_o, RfRd_o, RfWd_o, LluReady_o);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b1 || PendingRd_o !== 5'd7 || LluReady_o !== 1'b0) begin
      errors++;
      $display("FAIL buf_held got pv=%b prd=%0d rdy=%b required 1/7/0", PendingValid_o, PendingRd_o, LluReady_o);
    end
    checks++;
    if (RfWe_o !== 1'b1 || RfRd_o !== 5'd7 || RfWd_o !== 32'h22) begin
      errors++;
      $display("FAIL buf_drain got we=%b x%0d=%h required x7=22", RfWe_o, RfRd_o, RfWd_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b0 || PendingRd_o !== 5'd0 || LluReady_o !== 1'b1 || RfWe_o !== 1'b0) begin
      errors++;
      $display("FAIL buf_idle got pv=%b prd=%0d rdy=%b we=%b required 0/0/1/0", PendingValid_o, PendingRd_o, LluReady_o, RfWe_o);
    end
  endtask

  task automatic test_starve();
    next_cycle();
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
    @(negedge clk_i);
    for (int i = 0; i < LIMIT; i++) begin
      next_cycle();
      drive(1'b1, 5'(2 + i), 32'h200 + 32'(i), 1'b0, 5'd0, 32'h0);
      @(negedge clk_i);
      checks++;
      if (RfWe_o !== 1'b1 || RfRd_o !== 5'(2 + i) || RfWd_o !== 32'h200 + 32'(i) ||
          StallPipe_o !== 1'b0 || PendingValid_o !== 1'b1) begin
        errors++;
        $display("FAIL starve_held%0d got we=%b x%0d=%h stall=%b pv=%b required x%0d=%h stall=0 pv=1",
                 i, RfWe_o, RfRd_o, RfWd_o, StallPipe_o, PendingValid_o, 2 + i, 32'h200 + 32'(i));
      end
    end
    next_cycle();
    drive(1'b1, 5'd6, 32'h206, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (StallPipe_o !== 1'b1 || RfWe_o !== 1'b1 || RfRd_o !== 5'd9 || RfWd_o !== 32'h99 || LluReady_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_drain got stall=%b we=%b x%0d=%h rdy=%b required stall=1 x9=99 rdy=0",
               StallPipe_o, RfWe_o, RfRd_o, RfWd_o, LluReady_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if (StallPipe_o !== 1'b0 || RfWe_o !== 1'b1 || RfRd_o !== 5'd6 || RfWd_o !== 32'h206 ||
        PendingValid_o !== 1'b0 || LluReady_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_after got stall=%b we=%b x%0d=%h pv=%b rdy=%b required stall=0 x6=206 pv=0 rdy=1",
               StallPipe_o, RfWe_o, RfRd_o, RfWd_o, PendingValid_o, LluReady_o);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_x0();
    next_cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h55);
    @(negedge clk_i);
    checks++;
    if (RfWe_o !== 1'b1 || RfRd_o !== 5'd4 || RfWd_o !== 32'h44 || LluReady_o !== 1'b1) begin
      errors++;
      $display("FAIL x0_llu got we=%b x%0d=%h rdy=%b required x4=44 rdy=1", RfWe_o, RfRd_o, RfWd_o, LluReady_o);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b0 || RfWe_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_llu_drop got pv=%b we=%b required 0/0", PendingValid_o, RfWe_o);
    end
    next_cycle();
    drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd6, 32'h66);
    @(negedge clk_i);
    checks++;
    if (RfWe_o !== 1'b1 || RfRd_o !== 5'd6 || RfWd_o !== 32'h66) begin
      errors++;
      $display("FAIL x0_w_pass got we=%b x%0d=%h required x6=66", RfWe_o, RfRd_o, RfWd_o);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b0) begin errors++; $display("FAIL x0_w_nobuf got pv=%b required 0", PendingValid_o); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd12, 32'hC12);
    @(negedge clk_i);
    next_cycle();
    drive(1'b1, 5'd4, 32'h32, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    checks++;
    if (PendingValid_o !== 1'b1 || PendingRd_o !== 5'd12) begin
      errors++;
      $display("FAIL areset_held got pv=%b prd=%0d required 1/12", PendingValid_o, PendingRd_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (RfWe_o !== 1'b0 || PendingValid_o !== 1'b0 || LluReady_o !== 1'b0 || PendingRd_o !== 5'd0) begin
      errors++;
      $display("FAIL areset_now got we=%b pv=%b rdy=%b prd=%0d required 0/0/0/0", RfWe_o, PendingValid_o, LluReady_o, PendingRd_o);
    end
    @(posedge clk_i);
    #2;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (LluReady_o !== 1'b1 || PendingValid_o !== 1'b0 || PendingRd_o !== 5'd0) begin
      errors++;
      $display("FAIL areset_release got rdy=%b pv=%b prd=%0d required 1/0/0", LluReady_o, PendingValid_o, PendingRd_o);
    end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk_i);
      checks++;
      if (RfWe_o !== 1'b0) begin errors++; $display("FAIL areset_nowrite%0d got we=%b x%0d required 0", i, RfWe_o, RfRd_o); end
    end
  endtask

  task automatic test_random();
    logic          stall, xfer, prev_stall;
    logic          wv, lv;
    logic [AW-1:0] wrd, lrd;
    logic [DW-1:0] wd, ld;
    wr_t           e;
    int            idx;
    int            seq;
    w_q.delete();
    l_q.delete();
    stall = 1'b0; xfer = 1'b0; prev_stall = 1'b0;
    wv = 1'b0; wrd = '0; wd = '0; lv = 1'b0; lrd = '0; ld = '0;
    seq = 0;
    next_cycle();
    for (int n = 0; n < NCYC + 40; n++) begin
      // W advances unless the previous cycle froze the pipeline.
      if (!stall) begin
        if (n < NCYC) begin
          wv  = ($urandom_range(0, 9) < 7);
          wrd = 5'($urandom_range(0, 31));
        end else begin
          wv  = 1'b0;
          wrd = '0;
        end
        seq++;
        wd = {1'b0, 31'(seq)};
        if (wv && wrd != '0) begin
          e.rd = wrd; e.d = wd;
          w_q.push_back(e);
        end
      end
      // LLU holds its result until accepted.
      if (xfer) lv = 1'b0;
      if (!lv && n < NCYC && $urandom_range(0, 9) < 4) begin
        lv  = 1'b1;
        lrd = 5'($urandom_range(0, 31));
        seq++;
        ld  = {1'b1, 31'(seq)};
      end
      drive(wv, wrd, wd, lv, lrd, ld);
      @(negedge clk_i);
      stall = StallPipe_o;
      xfer  = LluValid_i & LluReady_o;
      if (xfer && LluRd_i != '0) begin
        e.rd = LluRd_i; e.d = LluResult_i;
        l_q.push_back(e);
      end
      if (RfWe_o) begin
        checks++;
        if (!RfWd_o[DW-1]) begin
          if (w_q.size() == 0) begin
            errors++;
            $display("FAIL rand_w_extra got x%0d=%h required no W write", RfRd_o, RfWd_o);
          end else begin
            e = w_q.pop_front();
            if (e.rd !== RfRd_o || e.d !== RfWd_o) begin
              errors++;
              $display("FAIL rand_w_order got x%0d=%h required x%0d=%h", RfRd_o, RfWd_o, e.rd, e.d);
            end
          end
        end else begin
          idx = -1;
          for (int i = 0; i < l_q.size(); i++)
            if (idx < 0 && l_q[i].rd == RfRd_o && l_q[i].d == RfWd_o) idx = i;
          if (idx < 0) begin
            errors++;
            $display("FAIL rand_llu_unexpected got x%0d=%h required an accepted LLU result", RfRd_o, RfWd_o);
          end else begin
            l_q.delete(idx);
          end
        end
      end
      if (stall) begin
        checks++;
        if (prev_stall) begin
          errors++;
          $display("FAIL rand_stall_consec got stall two cycles in a row at n=%0d required single", n);
        end
      end
      prev_stall = stall;
      next_cycle();
    end
    checks++;
    if (w_q.size() != 0) begin errors++; $display("FAIL rand_w_lost got %0d unwritten required 0", w_q.size()); end
    checks++;
    if (l_q.size() != 0 || lv) begin
      errors++;
      $display("FAIL rand_llu_lost got %0d unwritten pending=%b required 0", l_q.size(), lv);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_passthrough();
    test_buffer();
    test_starve();
    test_x0();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
